// File: rtl/sort_pkg.sv
// Shared defaults, FSM state type and error-flag layout for the sort result collector.
package sort_pkg;

  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefAw    = 4;
  localparam int unsigned DefDw    = 8;

  typedef enum logic [1:0] {
    StCollect,
    StCheck,
    StDrain
  } state_e;

  // Bit positions inside the packed error status vector.
  localparam int unsigned ErrMissingBit = 0;
  localparam int unsigned ErrDupBit     = 1;
  localparam int unsigned ErrOrderBit   = 2;
  localparam int unsigned ErrW          = 3;

endpackage

// File: rtl/iram_store.sv
// Register-array result store with one write port and drain/scan read ports.
// SORT_CHECK_EN adds the written mask, duplicate detect and the scan read port.
module iram_store import sort_pkg::*; #(
  parameter int unsigned Depth = DefDepth,
  parameter int unsigned Aw    = DefAw,
  parameter int unsigned Dw    = DefDw
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [Dw-1:0] wdata_i,
  input  logic [Aw-1:0] raddr_a_i,
  output logic [Dw-1:0] rdata_a_o
`ifdef SORT_CHECK_EN
  ,
  input  logic          clr_i,
  input  logic [Aw-1:0] raddr_b_i,
  output logic [Dw-1:0] rdata_b_o,
  output logic          all_written_o,
  output logic          dup_o
`endif
);

  logic [Dw-1:0] mem_q [Depth];
  logic [Dw-1:0] mem_d [Depth];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];

`ifdef SORT_CHECK_EN
  logic [Depth-1:0] mask_q, mask_d;
  logic             dup_q, dup_d;

  always_comb begin
    mask_d = mask_q;
    dup_d  = dup_q;
    if (clr_i) begin
      mask_d = '0;
      dup_d  = 1'b0;
    end else if (we_i) begin
      if (mask_q[waddr_i]) begin
        dup_d = 1'b1;
      end
      mask_d[waddr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
      dup_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      dup_q  <= dup_d;
    end
  end

  assign rdata_b_o     = mem_q[raddr_b_i];
  // Next-state view so a write coinciding with the done edge is included.
  assign all_written_o = &mask_d;
  assign dup_o         = dup_d;
`endif

endmodule

// File: rtl/iram_collector.sv
// Collects the sorter's IRAM writes, optionally checks them, then drains 16 bytes in order.
// SORT_CHECK_EN enables the CHECK scan and the err_* flags; otherwise they are tied to 0.
module iram_collector import sort_pkg::*; #(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = DefDw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IRAM_valid,
  input  logic [AW-1:0] IRAM_A,
  input  logic [DW-1:0] IRAM_D,
  input  logic          done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          err_missing,
  output logic          err_dup,
  output logic          err_order
);

  state_e        state_q, state_d;
  logic          done_q;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          done_rise, we, hs;
  logic [AW-1:0] raddr_a;
  logic [DW-1:0] rdata_a;

`ifdef SORT_CHECK_EN
  logic [AW-1:0]   scan_q, scan_d;
  logic [ErrW-1:0] err_q, err_d;
  logic [DW-1:0]   rdata_b;
  logic            all_written, dup_seen, clr;
`endif

  assign done_rise = done & ~done_q;
  assign we        = IRAM_valid && (state_q == StCollect);
  assign out_valid = (state_q == StDrain);
  assign out_last  = out_valid && (rd_ptr_q == AW'(DEPTH - 1));
  assign out_data  = out_valid ? rdata_a : '0;
  assign busy      = (state_q != StCollect);
  assign hs        = out_valid & out_ready;

`ifdef SORT_CHECK_EN
  // During the scan port A supplies mem[i+1]; otherwise it follows the drain pointer.
  assign raddr_a     = (state_q == StCheck) ? scan_q + AW'(1) : rd_ptr_q;
  assign err_missing = err_q[ErrMissingBit];
  assign err_dup     = err_q[ErrDupBit];
  assign err_order   = err_q[ErrOrderBit];
`else
  assign raddr_a     = rd_ptr_q;
  assign err_missing = 1'b0;
  assign err_dup     = 1'b0;
  assign err_order   = 1'b0;
`endif

  iram_store #(
    .Depth(DEPTH),
    .Aw   (AW),
    .Dw   (DW)
  ) u_store (
    .clk_i        (clk),
    .rst_ni       (reset),
    .we_i         (we),
    .waddr_i      (IRAM_A),
    .wdata_i      (IRAM_D),
    .raddr_a_i    (raddr_a),
    .rdata_a_o    (rdata_a)
`ifdef SORT_CHECK_EN
    ,
    .clr_i        (clr),
    .raddr_b_i    (scan_q),
    .rdata_b_o    (rdata_b),
    .all_written_o(all_written),
    .dup_o        (dup_seen)
`endif
  );

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
`ifdef SORT_CHECK_EN
    scan_d   = scan_q;
    err_d    = err_q;
    clr      = 1'b0;
`endif
    case (state_q)
      StCollect: begin
        if (done_rise) begin
`ifdef SORT_CHECK_EN
          state_d              = StCheck;
          scan_d               = '0;
          err_d[ErrMissingBit] = ~all_written;
          err_d[ErrDupBit]     = dup_seen;
          err_d[ErrOrderBit]   = 1'b0;
`else
          state_d = StDrain;
`endif
        end
      end
`ifdef SORT_CHECK_EN
      StCheck: begin
        if (rdata_b > rdata_a) begin
          err_d[ErrOrderBit] = 1'b1;
        end
        if (scan_q == AW'(DEPTH - 2)) begin
          state_d = StDrain;
        end else begin
          scan_d = scan_q + AW'(1);
        end
      end
`endif
      StDrain: begin
        if (hs) begin
          if (out_last) begin
            state_d  = StCollect;
            rd_ptr_d = '0;
`ifdef SORT_CHECK_EN
            clr      = 1'b1;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StCollect;
      done_q   <= 1'b1;
      rd_ptr_q <= '0;
`ifdef SORT_CHECK_EN
      scan_q   <= '0;
      err_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      done_q   <= done;
      rd_ptr_q <= rd_ptr_d;
`ifdef SORT_CHECK_EN
      scan_q   <= scan_d;
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_iram_collector.sv
// Randomized self-checking bench for iram_collector against an array-based reference model.
module tb_iram_collector;

  localparam int Depth = 16;
`ifdef SORT_CHECK_EN
  localparam bit CheckEn = 1'b1;
  localparam int Lat     = Depth;
`else
  localparam bit CheckEn = 1'b0;
  localparam int Lat     = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       IRAM_valid;
  logic [3:0] IRAM_A;
  logic [7:0] IRAM_D;
  logic       done;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       err_missing;
  logic       err_dup;
  logic       err_order;

  always #5 clk = ~clk;

  iram_collector dut (
    .clk        (clk),
    .reset      (reset),
    .IRAM_valid (IRAM_valid),
    .IRAM_A     (IRAM_A),
    .IRAM_D     (IRAM_D),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .err_missing(err_missing),
    .err_dup    (err_dup),
    .err_order  (err_order)
  );

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] mem_m [Depth];
  int         cnt_m [Depth];
  wr_t        wq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand_write();
    IRAM_valid = 1'($urandom_range(0, 1));
    IRAM_A     = 4'($urandom);
    IRAM_D     = 8'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {18'd0, out_valid, out_last, busy, err_missing, err_dup, err_order, out_data},
             32'd0);
  endtask

  // mode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready.
  // abort_at >= 0 asserts reset when that byte index is on the port.
  task automatic run_round(input int mode, input int abort_at);
    bit e_miss, e_dup, e_ord, r;
    int n, idx, cyc;
    int pat[4] = '{1, 0, 0, 1};
    for (int i = 0; i < Depth; i++) cnt_m[i] = 0;
    if (wq.size() == 0) begin
      done = 1'b1;
      step();
    end else begin
      for (int j = 0; j < wq.size(); j++) begin
        IRAM_valid = 1'b1;
        IRAM_A     = wq[j].a;
        IRAM_D     = wq[j].d;
        done       = (j == wq.size() - 1);
        step();
        mem_m[wq[j].a] = wq[j].d;
        cnt_m[wq[j].a]++;
      end
    end
    e_miss = 1'b0;
    e_dup  = 1'b0;
    e_ord  = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (cnt_m[i] == 0) e_miss = 1'b1;
      if (cnt_m[i] > 1) e_dup = 1'b1;
      if (i < Depth - 1 && mem_m[i] > mem_m[i+1]) e_ord = 1'b1;
    end
    if (!CheckEn) begin
      e_miss = 1'b0;
      e_dup  = 1'b0;
      e_ord  = 1'b0;
    end
    n = 1;
    while (!out_valid && n < Lat + 4) begin
      check_eq("busy_check", busy, 1);
      drive_rand_write();
      step();
      n++;
    end
    check_eq("latency", n, Lat);
    check_eq("err_missing", err_missing, e_miss);
    check_eq("err_dup", err_dup, e_dup);
    check_eq("err_order", err_order, e_ord);
    idx = 0;
    cyc = 0;
    while (idx < Depth && cyc < 200) begin
      check_eq("drain_valid", out_valid, 1);
      if (!out_valid) break;
      check_eq("out_data", out_data, mem_m[idx]);
      check_eq("out_last", out_last, idx == Depth - 1);
      check_eq("busy_drain", busy, 1);
      if (abort_at == idx) begin
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_drain");
        for (int i = 0; i < Depth; i++) mem_m[i] = 8'h00;
        IRAM_valid = 1'b0;
        out_ready  = 1'b0;
        return;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[cyc % 4] != 0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      drive_rand_write();
      step();
      if (r) idx++;
      cyc++;
    end
    check_eq("drain_count", idx, Depth);
    IRAM_valid = 1'b0;
    out_ready  = 1'b0;
    done       = 1'b0;
    check_eq("post_valid", out_valid, 0);
    check_eq("post_busy", busy, 0);
    check_eq("hold_flags", {err_missing, err_dup, err_order}, {e_miss, e_dup, e_ord});
    step();
  endtask

  task automatic fill_normal(input bit swap);
    wr_t w;
    wq.delete();
    for (int a = Depth - 1; a >= 0; a--) begin
      w.a = 4'(a);
      w.d = 8'(a * 16);
      if (swap && a == 3) w.d = 8'h40;
      if (swap && a == 4) w.d = 8'h30;
      wq.push_back(w);
    end
  endtask

  task automatic fill_missdup();
    wr_t w;
    wq.delete();
    for (int a = 0; a < Depth; a++) begin
      if (a != 9) begin
        w.a = 4'(a);
        w.d = 8'(a * 16 + 1);
        wq.push_back(w);
      end
    end
    w.a = 4'd5;
    w.d = 8'h55;
    wq.push_back(w);
  endtask

  task automatic fill_random(input bit sorted);
    logic [7:0] v[Depth];
    logic [7:0] t;
    int         perm[Depth];
    int         j, tp, n;
    wr_t        w;
    wq.delete();
    if (sorted) begin
      for (int i = 0; i < Depth; i++) v[i] = 8'($urandom);
      for (int i = 1; i < Depth; i++) begin
        for (int k = i; k > 0 && v[k-1] > v[k]; k--) begin
          t      = v[k];
          v[k]   = v[k-1];
          v[k-1] = t;
        end
      end
      for (int i = 0; i < Depth; i++) perm[i] = i;
      for (int i = Depth - 1; i > 0; i--) begin
        j       = int'($urandom_range(0, i));
        tp      = perm[i];
        perm[i] = perm[j];
        perm[j] = tp;
      end
      for (int i = 0; i < Depth; i++) begin
        w.a = 4'(perm[i]);
        w.d = v[perm[i]];
        wq.push_back(w);
      end
    end else begin
      n = int'($urandom_range(10, 24));
      for (int i = 0; i < n; i++) begin
        w.a = 4'($urandom);
        w.d = 8'($urandom);
        wq.push_back(w);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    IRAM_valid = 1'b0;
    IRAM_A     = '0;
    IRAM_D     = '0;
    done       = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < Depth; i++) mem_m[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b1;
    step();

    fill_normal(1'b0);
    run_round(0, -1);
    fill_normal(1'b1);
    run_round(0, -1);
    fill_missdup();
    run_round(0, -1);
    fill_normal(1'b0);
    run_round(1, -1);
    for (int r = 0; r < 6; r++) begin
      fill_random(r % 2 == 0);
      run_round(r % 3, -1);
    end

    fill_normal(1'b0);
    run_round(0, 5);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_all_zero("no_drain_done_held");
    end
    done = 1'b0;
    step();
    wq.delete();
    run_round(2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iram_collector.md
# iram_collector

Write-side responder for the sorter's result RAM port: captures the sorter's IRAM write stream (valid/address/data) into a local 16-entry store and tracks which addresses were written. On the sorter's `done` rising edge it checks the result for completeness and ascending order. It then streams the 16 bytes out, address 0 first, over a valid/ready port to the downstream consumer or testbench scoreboard. It stands in for the IRAM at the end of the sort pipeline.

## Interface
- DEPTH, 16, number of entries; must equal 2**AW
- AW, 4, address width
- DW, 8, data width
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- IRAM_valid  in  1  write strobe from sorter
- IRAM_A  in  AW  write address
- IRAM_D  in  DW  write data
- done  in  1  sorter completion level; rising edge starts check/drain
- out_valid  out  1  output byte valid
- out_ready  in  1  consumer accepts byte
- out_data  out  DW  output byte
- out_last  out  1  high with entry DEPTH-1
- busy  out  1  high in CHECK or DRAIN
- err_missing  out  1  some address never written
- err_dup  out  1  some address written more than once
- err_order  out  1  entry i > entry i+1 for some i

## Operation
- States: COLLECT (reset state), CHECK, DRAIN.
- COLLECT
  - IRAM_valid=1 writes IRAM_D to mem[IRAM_A] and sets mask[IRAM_A].
  - A write to an address whose mask bit is already set sets dup_seen.
  - done rise = done & ~done_q (done_q registered) -> CHECK.
  - A write in the same cycle as the done rise is captured.
- CHECK
  - On entry: err_missing <= ~&mask, err_dup <= dup_seen, err_order <= 0.
  - Scans i = 0..DEPTH-2, one compare per cycle (DEPTH-1 cycles).
  - Unsigned compare; err_order sets sticky if mem[i] > mem[i+1]; equal values are legal.
  - After the last compare -> DRAIN.
- DRAIN
  - out_valid=1, out_data=mem[rd_ptr], out_last=(rd_ptr==DEPTH-1).
  - rd_ptr advances on out_valid & out_ready.
  - out_data/out_last stay stable while out_ready=0.
  - Handshake with out_last -> COLLECT; clears mask, dup_seen and rd_ptr.
- Error flags hold their value until the next CHECK entry.
- IRAM writes and done edges in CHECK/DRAIN are ignored: no store update, no flag.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0, busy=0, all err_*=0.
  - mem all 0, mask 0, dup_seen=0, rd_ptr=0, state=COLLECT.
  - done_q=1: a done held high through reset release does not trigger.
- Reset mid-CHECK/DRAIN aborts immediately; a partial drain is not resumed.
- Done rise sampled at edge k -> CHECK during cycles k+1..k+DEPTH-1.
- First out_valid in cycle k+DEPTH, with err_* already final.
- With out_ready held 1: one byte per cycle, DEPTH cycles; back in COLLECT the cycle after the out_last handshake.
- Rounds restart only on a new done rise, so done must fall and rise again.

## Configuration
- SORT_CHECK_EN defined: CHECK state, mask, dup_seen and all error logic built as above.
- SORT_CHECK_EN undefined:
  - No CHECK state; done rise at edge k gives first out_valid in cycle k+1.
  - mask/dup_seen are not built.
  - err_missing, err_dup, err_order are tied to 0.
  - busy covers DRAIN only.

## Structure
- Package sort_pkg holds:
  - DEPTH/AW/DW defaults.
  - State enum {COLLECT, CHECK, DRAIN}.
  - Error-flag bit positions for a packed status vector.
- One sub-module, iram_store: DEPTH x DW register array with write port and two read ports (rd_ptr, scan index).
  - Under SORT_CHECK_EN it also holds the written mask and duplicate detect.
- The FSM, scan counter, handshake and flags stay in the top module.

## Test plan
- Normal sort result: write 15..0 with data 8'hF0..8'h00 descending by address (addr 15 = 8'hF0), raise done, out_ready=1.
  - Expect 16 bytes 8'h00,8'h10..8'hF0; out_last on the 16th; all err_*=0; first out_valid 16 cycles after the done edge.
- Order error: as the normal case, but swap the data at addr 3 and 4.
  - Expect err_order=1, err_missing=0, err_dup=0; drain shows the swapped bytes.
- Missing/dup: write addr 5 twice and skip addr 9.
  - Expect err_dup=1, err_missing=1; entry 9 drains as 0 after reset (or the previous round's value).
- Backpressure: toggle out_ready 1,0,0,1 during the drain.
  - Expect out_data stable while stalled; exactly 16 accepted bytes, no repeats or skips.
- Reset interplay:
  - Assert reset mid-DRAIN: all outputs go to 0 at once.
  - Release reset with done held 1: no drain starts.
  - Drop done then raise it: a new drain starts.
- Build without SORT_CHECK_EN: normal-case stimulus.
  - Expect first out_valid 1 cycle after the done edge; err_* constant 0.
